axi_ram_ctrl: RTL and testbench

AXI_RAM_CTRL -- requirements
Module: axi_ram_ctrl

---
 rtl/axi_ram_ctrl_if.sv | 44 ++++
 rtl/axi_ram_ctrl.sv | 115 +++++++++++
 tb/tb_axi_ram_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ram_ctrl_if.sv
// axi_ram_ctrl_if: AXI4 bundle with a shared read/write address channel.
interface axi_ram_ctrl_if #(
    parameter int ADDR_BITS = 14
);
    logic                 axi_arw_valid;
    logic                 axi_arw_ready;
    logic [ADDR_BITS-1:0] axi_arw_payload_addr;
    logic                 axi_arw_payload_id;
    logic [7:0]           axi_arw_payload_len;
    logic [2:0]           axi_arw_payload_size;
    logic [1:0]           axi_arw_payload_burst;
    logic                 axi_arw_payload_write;
    logic                 axi_w_valid;
    logic                 axi_w_ready;
    logic [31:0]          axi_w_payload_data;
    logic [3:0]           axi_w_payload_strb;
    logic                 axi_w_payload_last;
    logic                 axi_b_valid;
    logic                 axi_b_ready;
    logic                 axi_b_payload_id;
    logic                 axi_r_valid;
    logic                 axi_r_ready;
    logic [31:0]          axi_r_payload_data;
    logic                 axi_r_payload_id;
    logic                 axi_r_payload_last;

    modport master (
        output axi_arw_valid, axi_arw_payload_addr, axi_arw_payload_id, axi_arw_payload_len,
               axi_arw_payload_size, axi_arw_payload_burst, axi_arw_payload_write,
               axi_w_valid, axi_w_payload_data, axi_w_payload_strb, axi_w_payload_last,
               axi_b_ready, axi_r_ready,
        input  axi_arw_ready, axi_w_ready, axi_b_valid, axi_b_payload_id,
               axi_r_valid, axi_r_payload_data, axi_r_payload_id, axi_r_payload_last
    );

    modport slave (
        input  axi_arw_valid, axi_arw_payload_addr, axi_arw_payload_id, axi_arw_payload_len,
               axi_arw_payload_size, axi_arw_payload_burst, axi_arw_payload_write,
               axi_w_valid, axi_w_payload_data, axi_w_payload_strb, axi_w_payload_last,
               axi_b_ready, axi_r_ready,
        output axi_arw_ready, axi_w_ready, axi_b_valid, axi_b_payload_id,
               axi_r_valid, axi_r_payload_data, axi_r_payload_id, axi_r_payload_last
    );
endinterface

// File: rtl/axi_ram_ctrl.sv
// axi_ram_ctrl: AXI4 slave (shared AR/AW) driving a single-port 32-bit RAM.
// Reads are prefetched into a 2-entry FIFO so r_ready back-pressure never drops data.
module axi_ram_ctrl #(
    parameter int ADDR_BITS      = 14,
    parameter int WORD_ADDR_BITS = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    axi_ram_ctrl_if.slave             axi,
    output logic                      ram_en,
    output logic                      ram_wr,
    output logic [WORD_ADDR_BITS-1:0] ram_addr,
    output logic [3:0]                ram_mask,
    output logic [31:0]               ram_wrData,
    input  logic [31:0]               ram_rdData
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, WRESP} state_t;
    state_t                    state, state_next;
    logic [WORD_ADDR_BITS-1:0] addr, addr_inc, addr_next, wrap_mask;
    logic [7:0]                len;
    logic [1:0]                burst;
    logic                      id;
    logic [8:0]                left;
    logic                      pend, pend_last;
    logic [31:0]               fifo_data [2];
    logic [1:0]                fifo_last;
    logic                      wp, rp;
    logic [1:0]                count;
    logic                      arw_hs, w_hs, b_hs, r_hs, issue, wrap_ok;
    logic                      unused;

    assign unused = ^{axi.axi_arw_payload_size, axi.axi_w_payload_last, axi.axi_arw_payload_addr[1:0]};

    assign arw_hs = axi.axi_arw_valid && state == IDLE;
    assign w_hs   = axi.axi_w_valid && state == WRITE;
    assign b_hs   = axi.axi_b_ready && state == WRESP;
    assign r_hs   = axi.axi_r_valid && axi.axi_r_ready;
    // A pop in the same cycle frees a slot, keeping reads streaming at one beat per cycle.
    assign issue  = state == READ && left != 9'd0 &&
                    ({1'b0, count} + {2'b0, pend} - {2'b0, r_hs}) < 3'd2;

    assign wrap_ok   = len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
    assign wrap_mask = WORD_ADDR_BITS'(len);
    assign addr_inc  = addr + WORD_ADDR_BITS'(1);
    assign addr_next = burst == 2'd0 ? addr
                     : burst == 2'd2 && wrap_ok ? (addr & ~wrap_mask) | (addr_inc & wrap_mask)
                     : addr_inc;

    assign axi.axi_arw_ready      = state == IDLE;
    assign axi.axi_w_ready        = state == WRITE;
    assign axi.axi_b_valid        = state == WRESP;
    assign axi.axi_b_payload_id   = id;
    assign axi.axi_r_valid        = count != 2'd0;
    assign axi.axi_r_payload_data = axi.axi_r_valid ? fifo_data[rp] : 32'd0;
    assign axi.axi_r_payload_last = axi.axi_r_valid && fifo_last[rp];
    assign axi.axi_r_payload_id   = id;

    assign ram_en     = w_hs || issue;
    assign ram_wr     = w_hs;
    assign ram_addr   = addr;
    assign ram_mask   = w_hs ? axi.axi_w_payload_strb : 4'd0;
    assign ram_wrData = w_hs ? axi.axi_w_payload_data : 32'd0;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_next;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (arw_hs) state_next = axi.axi_arw_payload_write ? WRITE : READ;
            WRITE:   if (w_hs && left == 9'd1) state_next = WRESP;
            WRESP:   if (b_hs) state_next = IDLE;
            READ:    if (r_hs && axi.axi_r_payload_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            addr      <= '0;
            len       <= '0;
            burst     <= '0;
            id        <= 1'b0;
            left      <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
            fifo_last <= '0;
            wp        <= 1'b0;
            rp        <= 1'b0;
            count     <= '0;
        end else begin
            if (arw_hs) begin
                addr  <= axi.axi_arw_payload_addr[ADDR_BITS-1:2];
                len   <= axi.axi_arw_payload_len;
                burst <= axi.axi_arw_payload_burst;
                id    <= axi.axi_arw_payload_id;
                left  <= {1'b0, axi.axi_arw_payload_len} + 9'd1;
            end else if (w_hs || issue) begin
                addr <= addr_next;
                left <= left - 9'd1;
            end
            pend      <= issue;
            pend_last <= left == 9'd1;
            if (pend) begin
                fifo_last[wp] <= pend_last;
                wp            <= ~wp;
            end
            if (r_hs) rp <= ~rp;
            count <= count + {1'b0, pend} - {1'b0, r_hs};
        end

    always_ff @(posedge clk)
        if (pend) fifo_data[wp] <= ram_rdData;
endmodule

// File: tb/tb_axi_ram_ctrl.sv
// tb_axi_ram_ctrl: randomized AXI traffic against a word-level memory/address model.
module tb_axi_ram_ctrl;
    localparam int AW    = 14;
    localparam int WAW   = 12;
    localparam int DEPTH = 4096;

    logic            clk = 1'b0;
    logic            reset;
    logic            fill;
    logic            ram_en, ram_wr;
    logic [WAW-1:0]  ram_addr;
    logic [3:0]      ram_mask;
    logic [31:0]     ram_wrData, ram_rdData;
    logic [31:0]     mem     [DEPTH];
    logic [31:0]     ref_mem [DEPTH];
    int              checks = 0;
    int              failures = 0;

    always #5 clk = ~clk;

    axi_ram_ctrl_if #(.ADDR_BITS(AW)) ax ();

    axi_ram_ctrl #(.ADDR_BITS(AW), .WORD_ADDR_BITS(WAW)) dut (
        .clk(clk), .reset(reset), .axi(ax),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_mask(ram_mask),
        .ram_wrData(ram_wrData), .ram_rdData(ram_rdData)
    );

    function automatic logic [31:0] fill_val(input int k);
        return 32'(k) * 32'h9E37_79B9 ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r = old;
        for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    // Word address of the beat after w, from the burst rules.
    function automatic int unsigned nxt(input int unsigned w, input int len, input int burst);
        int unsigned span = 32'(len + 1);
        if (burst == 0) return w;
        if (burst == 2 && (span == 2 || span == 4 || span == 8 || span == 16))
            return w - w % span + (w + 1) % span;
        return (w + 1) % DEPTH;
    endfunction

    always @(posedge clk) begin
        if (fill) for (int k = 0; k < DEPTH; k++) mem[k] <= fill_val(k);
        else if (ram_en && ram_wr) mem[ram_addr] <= merge(mem[ram_addr], ram_wrData, ram_mask);
        if (ram_en && !ram_wr) ram_rdData <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive_arw(input logic [AW-1:0] a, input logic i, input int len, input int burst, input logic wr);
        ax.axi_arw_valid         = 1'b1;
        ax.axi_arw_payload_addr  = a;
        ax.axi_arw_payload_id    = i;
        ax.axi_arw_payload_len   = 8'(len);
        ax.axi_arw_payload_size  = 3'($urandom);
        ax.axi_arw_payload_burst = 2'(burst);
        ax.axi_arw_payload_write = wr;
        @(negedge clk);
        check("arw_ready", 64'(ax.axi_arw_ready), 64'd1);
        @(posedge clk); #1;
        ax.axi_arw_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic i, input int len, input int burst,
                            input logic [3:0] st, input int bwait, input bit gaps, input bit seq_data);
        int unsigned wa = 32'(a >> 2);
        int          beat = 0;
        logic [31:0] d;
        logic [3:0]  s;
        drive_arw(a, i, len, burst, 1'b1);
        while (beat <= len) begin
            d = seq_data ? 32'h11 * 32'(beat + 1) : $urandom;
            s = st != 4'd0 ? st : 4'($urandom);
            ax.axi_w_valid        = !gaps || ($urandom_range(0, 3) != 0);
            ax.axi_w_payload_data = d;
            ax.axi_w_payload_strb = s;
            ax.axi_w_payload_last = beat == len;
            @(negedge clk);
            check("w_ready", {ax.axi_w_ready, ax.axi_arw_ready}, 2'b10);
            if (ax.axi_w_valid) begin
                check("w_ram_cmd", {ram_en, ram_wr, ram_mask}, {2'b11, s});
                check("w_ram_addr", 64'(ram_addr), 64'(wa));
                check("w_ram_data", 64'(ram_wrData), 64'(d));
                ref_mem[wa] = merge(ref_mem[wa], d, s);
                wa = nxt(wa, len, burst);
                beat++;
            end else check("w_gap_ram_en", {ram_en, ram_wr}, 2'b00);
            @(posedge clk); #1;
        end
        ax.axi_w_valid        = 1'b0;
        ax.axi_w_payload_last = 1'b0;
        ax.axi_b_ready        = 1'b0;
        repeat (bwait) begin
            @(negedge clk);
            check("b_hold", {ax.axi_b_valid, ax.axi_arw_ready, ram_en}, 3'b100);
            @(posedge clk); #1;
        end
        ax.axi_b_ready = 1'b1;
        @(negedge clk);
        check("b_valid_id", {ax.axi_b_valid, ax.axi_b_payload_id}, {1'b1, i});
        @(posedge clk); #1;
        ax.axi_b_ready = 1'b0;
        @(negedge clk);
        check("b_done", {ax.axi_b_valid, ax.axi_arw_ready}, 2'b01);
        @(posedge clk); #1;
    endtask

    // mode 0: r_ready held 1, 1: toggling, 2: random. abort_beat>0 pulses reset after that beat.
    task automatic do_read(input logic [AW-1:0] a, input logic i, input int len, input int burst,
                           input int mode, input int abort_beat);
        int unsigned seq[$];
        int          iss_e[$];
        int unsigned wa = 32'(a >> 2);
        int          e = 0, got = 0, first_v = -1, first_hs = 0, last_hs = 0, occ, max_occ = 0;
        bit          stop = 1'b0;
        for (int k = 0; k <= len; k++) begin
            seq.push_back(wa);
            wa = nxt(wa, len, burst);
        end
        drive_arw(a, i, len, burst, 1'b0);
        while (!stop && got <= len && e < 64 + 8 * len) begin
            ax.axi_r_ready = mode == 0 ? 1'b1 : mode == 1 ? e[0] : 1'($urandom);
            @(negedge clk);
            if (first_v < 0 && ax.axi_r_valid) first_v = e;
            check("r_busy_arw_ready", 64'(ax.axi_arw_ready), 64'd0);
            occ = -got;
            foreach (iss_e[k]) if (iss_e[k] <= e - 2) occ++;
            if (occ > max_occ) max_occ = occ;
            if (ram_en) begin
                check("r_ram_wr", 64'(ram_wr), 64'd0);
                check("r_issue_count", 64'(iss_e.size() <= len), 64'd1);
                if (iss_e.size() <= len) check("r_ram_addr", 64'(ram_addr), 64'(seq[iss_e.size()]));
                iss_e.push_back(e);
            end
            if (ax.axi_r_valid && ax.axi_r_ready) begin
                check("r_data", 64'(ax.axi_r_payload_data), 64'(ref_mem[seq[got]]));
                check("r_id_last", {ax.axi_r_payload_id, ax.axi_r_payload_last}, {i, got == len});
                if (got == 0) first_hs = e;
                last_hs = e;
                got++;
                stop = got == abort_beat;
            end
            @(posedge clk); #1;
            e++;
        end
        ax.axi_r_ready = 1'b0;
        check("r_first_valid", 64'(first_v), 64'd2);
        check("r_max_occ", 64'(max_occ <= 2), 64'd1);
        if (stop) begin
            reset = 1'b1;
            @(negedge clk);
            check("rst_abort", {ax.axi_arw_ready, ax.axi_w_ready, ax.axi_b_valid, ax.axi_r_valid, ram_en, ram_wr}, 6'b100000);
            @(posedge clk); #1;
            reset = 1'b0;
            repeat (2) begin
                @(negedge clk);
                check("rst_no_resp", {ax.axi_r_valid, ax.axi_b_valid, ax.axi_arw_ready, ram_en}, 4'b0010);
                @(posedge clk); #1;
            end
        end else begin
            check("r_beats", 64'(got), 64'(len + 1));
            if (mode == 0) check("r_back_to_back", 64'(last_hs - first_hs), 64'(len));
            @(negedge clk);
            check("r_idle", {ax.axi_arw_ready, ax.axi_r_valid}, 2'b10);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [AW-1:0] ra;
        int            rl, rb;
        reset = 1'b1;
        fill  = 1'b1;
        ax.axi_arw_valid = 1'b0; ax.axi_arw_payload_addr = '0; ax.axi_arw_payload_id = 1'b0;
        ax.axi_arw_payload_len = '0; ax.axi_arw_payload_size = '0; ax.axi_arw_payload_burst = '0;
        ax.axi_arw_payload_write = 1'b0; ax.axi_w_valid = 1'b0; ax.axi_w_payload_data = '0;
        ax.axi_w_payload_strb = '0; ax.axi_w_payload_last = 1'b0; ax.axi_b_ready = 1'b0; ax.axi_r_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = fill_val(k);
        repeat (2) @(posedge clk);
        #1 fill = 1'b0;
        @(negedge clk);
        check("rst_ctrl", {ax.axi_arw_ready, ax.axi_w_ready, ax.axi_b_valid, ax.axi_r_valid, ram_en, ram_wr,
                           ax.axi_b_payload_id, ax.axi_r_payload_id, ax.axi_r_payload_last}, 9'b100000000);
        check("rst_ram", {ram_addr, ram_mask, ram_wrData}, 64'd0);
        check("rst_r_data", 64'(ax.axi_r_payload_data), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst", {ax.axi_arw_ready, ax.axi_w_ready, ax.axi_b_valid, ax.axi_r_valid, ram_en}, 5'b10000);
        @(posedge clk); #1;

        do_write(14'h1000, 1'b1, 3, 1, 4'hF, 0, 1'b0, 1'b1);
        do_read(14'h1000, 1'b0, 3, 1, 0, -1);
        do_read(14'h100C, 1'b1, 3, 2, 0, -1);
        do_read(14'h2000, 1'b0, 7, 1, 1, -1);
        do_write(14'h0040, 1'b1, 2, 1, 4'h5, 5, 1'b0, 1'b0);
        do_read(14'h0040, 1'b1, 2, 1, 2, -1);
        do_read(14'h1000, 1'b1, 7, 1, 0, 2);
        do_read(14'h1000, 1'b0, 7, 1, 0, -1);
        do_write(14'h3FFC, 1'b0, 3, 1, 4'hF, 1, 1'b0, 1'b0);
        do_read(14'h3FFC, 1'b0, 3, 1, 0, -1);
        do_write(14'h2004, 1'b1, 3, 0, 4'h0, 0, 1'b1, 1'b0);
        do_read(14'h2004, 1'b1, 3, 0, 0, -1);
        do_write(14'h0A3C, 1'b0, 15, 2, 4'hF, 2, 1'b1, 1'b0);
        do_read(14'h0A14, 1'b0, 7, 2, 2, -1);
        do_read(14'h0A00, 1'b1, 15, 2, 0, -1);
        do_read(14'h2010, 1'b1, 5, 2, 0, -1);

        for (int n = 0; n < 60; n++) begin
            ra = AW'($urandom);
            rl = $urandom_range(0, 15);
            rb = $urandom_range(0, 2);
            if ($urandom_range(0, 1) != 0)
                do_write(ra, 1'($urandom), rl, rb, 4'h0, $urandom_range(0, 3), 1'b1, 1'b0);
            else
                do_read(ra, 1'($urandom), rl, rb, $urandom_range(0, 2), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
